// File: rtl/mybullet_app.sv
// Player bullet: launches from the tank cell, steps one cell per clk_4Hz tick and reports enemy hits.
// DONE is the single cycle after a flight ends; it parks the outputs. Define MYBUL_FAST_EN to tick on both clk_4Hz edges.
module mybullet_app (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_4Hz,
  input  logic       bul_en,
  input  logic       bul_sht,
  input  logic [4:0] tank_x,
  input  logic [4:0] tank_y,
  input  logic [1:0] tank_dir,
  input  logic [4:0] enemy1_x,
  input  logic [4:0] enemy1_y,
  input  logic [4:0] enemy2_x,
  input  logic [4:0] enemy2_y,
  input  logic [4:0] enemy3_x,
  input  logic [4:0] enemy3_y,
  input  logic [4:0] enemy4_x,
  input  logic [4:0] enemy4_y,
  input  logic [3:0] enemy_alive,
  output logic [4:0] bul_x,
  output logic [4:0] bul_y,
  output logic       mybul_state_feedback,
  output logic [3:0] hit_enemy
);

  localparam logic [4:0] PARK  = 5'h1F;
  localparam logic [4:0] X_MAX = 5'd15;
  localparam logic [4:0] Y_MAX = 5'd19;

  typedef enum logic [1:0] {IDLE, FLY, DONE} state_t;

  state_t     state_q;
  logic       c4_prev_q;
  logic [1:0] dir_q;
  logic [4:0] bul_x_q;
  logic [4:0] bul_y_q;
  logic       fb_q;
  logic [3:0] hit_q;

  logic       tick;
  logic [4:0] step_x_d;
  logic [4:0] step_y_d;
  logic       step_off;
  logic       on_field;
  logic [3:0] hit_d;

`ifdef MYBUL_FAST_EN
  assign tick = clk_4Hz ^ c4_prev_q;
`else
  assign tick = clk_4Hz & ~c4_prev_q;
`endif

  always_comb begin
    step_x_d = bul_x_q;
    step_y_d = bul_y_q;
    case (dir_q)
      2'b00:   step_y_d = bul_y_q + 5'd1;
      2'b01:   step_y_d = bul_y_q - 5'd1;
      2'b10:   step_x_d = bul_x_q + 5'd1;
      default: step_x_d = bul_x_q - 5'd1;
    endcase
  end

  // Decrementing past 0 wraps to 31, so one upper-bound compare catches every exit.
  assign step_off = (step_x_d > X_MAX) || (step_y_d > Y_MAX);
  assign on_field = (bul_x_q <= X_MAX) && (bul_y_q <= Y_MAX);

  assign hit_d = on_field ? {enemy_alive[3] && (enemy4_x == bul_x_q) && (enemy4_y == bul_y_q),
                             enemy_alive[2] && (enemy3_x == bul_x_q) && (enemy3_y == bul_y_q),
                             enemy_alive[1] && (enemy2_x == bul_x_q) && (enemy2_y == bul_y_q),
                             enemy_alive[0] && (enemy1_x == bul_x_q) && (enemy1_y == bul_y_q)}
                          : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      c4_prev_q <= 1'b0;
      dir_q     <= 2'b00;
      bul_x_q   <= PARK;
      bul_y_q   <= PARK;
      fb_q      <= 1'b0;
      hit_q     <= 4'b0000;
    end else begin
      c4_prev_q <= clk_4Hz;
      hit_q     <= 4'b0000;
      case (state_q)
        IDLE: begin
          if (bul_sht && bul_en) begin
            state_q <= FLY;
            bul_x_q <= tank_x;
            bul_y_q <= tank_y;
            dir_q   <= tank_dir;
            fb_q    <= 1'b1;
          end
        end
        FLY: begin
          // A hit takes priority over a coincident tick; the bullet stays on the struck cell.
          if (|hit_d) begin
            hit_q   <= hit_d;
            state_q <= DONE;
          end else if (tick) begin
            if (step_off) begin
              state_q <= DONE;
            end else begin
              bul_x_q <= step_x_d;
              bul_y_q <= step_y_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          fb_q    <= 1'b0;
          bul_x_q <= PARK;
          bul_y_q <= PARK;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bul_x                = bul_x_q;
  assign bul_y                = bul_y_q;
  assign mybul_state_feedback = fb_q;
  assign hit_enemy            = hit_q;

endmodule

// File: tb/tb_mybullet_app.sv
// Bench for mybullet_app: directed scenarios plus a random run against a cell-level flight model.
module tb_mybullet_app;

`ifdef MYBUL_FAST_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, clk_4Hz, bul_en, bul_sht;
  logic [4:0] tank_x, tank_y;
  logic [1:0] tank_dir;
  logic [4:0] enemy1_x, enemy1_y, enemy2_x, enemy2_y;
  logic [4:0] enemy3_x, enemy3_y, enemy4_x, enemy4_y;
  logic [3:0] enemy_alive;
  logic [4:0] bul_x, bul_y;
  logic       mybul_state_feedback;
  logic [3:0] hit_enemy;

  int checks   = 0;
  int failures = 0;

  // Model: mode 0 = no bullet, 1 = flying, 2 = final cycle after hit/expiry.
  int         m_mode = 0;
  int         m_x = 0, m_y = 0, m_dx = 0, m_dy = 0;
  bit         m_prev = 0;
  logic [3:0] m_hit = 4'b0000;

  always #5 clk = ~clk;

  mybullet_app dut (
    .clk(clk), .rst(rst), .clk_4Hz(clk_4Hz), .bul_en(bul_en), .bul_sht(bul_sht),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
    .enemy1_x(enemy1_x), .enemy1_y(enemy1_y), .enemy2_x(enemy2_x), .enemy2_y(enemy2_y),
    .enemy3_x(enemy3_x), .enemy3_y(enemy3_y), .enemy4_x(enemy4_x), .enemy4_y(enemy4_y),
    .enemy_alive(enemy_alive), .bul_x(bul_x), .bul_y(bul_y),
    .mybul_state_feedback(mybul_state_feedback), .hit_enemy(hit_enemy)
  );

  function automatic logic [4:0] exp_bx();
    return (m_mode == 0) ? 5'd31 : 5'(m_x);
  endfunction
  function automatic logic [4:0] exp_by();
    return (m_mode == 0) ? 5'd31 : 5'(m_y);
  endfunction

  task automatic model_edge();
    bit         tk;
    int         nx, ny;
    int         ex[4], ey[4];
    logic [3:0] hits;
`ifdef MYBUL_FAST_EN
    tk = (clk_4Hz != m_prev);
`else
    tk = clk_4Hz && !m_prev;
`endif
    m_prev = clk_4Hz;
    m_hit  = 4'b0000;
    ex = '{int'(enemy1_x), int'(enemy2_x), int'(enemy3_x), int'(enemy4_x)};
    ey = '{int'(enemy1_y), int'(enemy2_y), int'(enemy3_y), int'(enemy4_y)};
    if (rst) begin
      m_mode = 0;
      m_prev = 0;
    end else if (m_mode == 0) begin
      if (bul_sht && bul_en) begin
        m_mode = 1;
        m_x = tank_x;
        m_y = tank_y;
        m_dx = (tank_dir == 2'b10) ? 1 : (tank_dir == 2'b11) ? -1 : 0;
        m_dy = (tank_dir == 2'b00) ? 1 : (tank_dir == 2'b01) ? -1 : 0;
      end
    end else if (m_mode == 1) begin
      hits = 4'b0000;
      for (int i = 0; i < 4; i++)
        if (enemy_alive[i] && ex[i] == m_x && ey[i] == m_y && m_x <= 15 && m_y <= 19)
          hits[i] = 1'b1;
      if (hits != 0) begin
        m_hit  = hits;
        m_mode = 2;
      end else if (tk) begin
        nx = m_x + m_dx;
        ny = m_y + m_dy;
        if (nx < 0 || nx > 15 || ny < 0 || ny > 19) m_mode = 2;
        else begin
          m_x = nx;
          m_y = ny;
        end
      end
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bul_sht = 1'b0; bul_en = 1'b0; clk_4Hz = 1'b0; enemy_alive = 4'b0000;
    cyc();
    rst = 1'b0;
  endtask

  task automatic launch(input int x, input int y, input logic [1:0] d);
    tank_x = 5'(x); tank_y = 5'(y); tank_dir = d; bul_sht = 1'b1; bul_en = 1'b1;
    cyc();
    bul_sht = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_4Hz = 1'b1; bul_sht = 1'b1; bul_en = 1'b1;
    cyc();
    checks += 4;
    if (bul_x !== 5'h1F) begin failures++; $display("FAIL reset_bul_x got %0d want 31", bul_x); end
    if (bul_y !== 5'h1F) begin failures++; $display("FAIL reset_bul_y got %0d want 31", bul_y); end
    if (mybul_state_feedback !== 1'b0) begin failures++; $display("FAIL reset_fb got %b want 0", mybul_state_feedback); end
    if (hit_enemy !== 4'b0000) begin failures++; $display("FAIL reset_hit got %b want 0000", hit_enemy); end
    // First edge after release may already launch.
    rst = 1'b0; clk_4Hz = 1'b0; tank_x = 5'd1; tank_y = 5'd2; tank_dir = 2'b00;
    cyc();
    checks += 2;
    if (mybul_state_feedback !== 1'b1) begin failures++; $display("FAIL first_shot_fb got %b want 1", mybul_state_feedback); end
    if (bul_x !== 5'd1 || bul_y !== 5'd2) begin failures++; $display("FAIL first_shot_cell got (%0d,%0d) want (1,2)", bul_x, bul_y); end
  endtask

  task automatic test_launch_fly();
    do_reset();
    launch(5, 5, 2'b00);
    checks += 2;
    if (mybul_state_feedback !== 1'b1) begin failures++; $display("FAIL launch_fb got %b want 1", mybul_state_feedback); end
    if (bul_x !== 5'd5 || bul_y !== 5'd5) begin failures++; $display("FAIL launch_cell got (%0d,%0d) want (5,5)", bul_x, bul_y); end
    repeat (3) begin
      clk_4Hz = 1'b1; cyc();
      clk_4Hz = 1'b0; cyc();
    end
    checks++;
    if (bul_x !== 5'd5 || bul_y !== 5'(5 + 3 * STEPS))
      begin failures++; $display("FAIL fly_3_ticks got (%0d,%0d) want (5,%0d)", bul_x, bul_y, 5 + 3 * STEPS); end
  endtask

  task automatic test_expire();
    do_reset();
    launch(3, 19, 2'b00);
    clk_4Hz = 1'b1; cyc();
    checks++;
    if (bul_x !== 5'd3 || bul_y !== 5'd19 || hit_enemy !== 4'b0000)
      begin failures++; $display("FAIL expire_no_move got (%0d,%0d) hit %b want (3,19) hit 0000", bul_x, bul_y, hit_enemy); end
    clk_4Hz = 1'b0; cyc();
    checks++;
    if (mybul_state_feedback !== 1'b0 || bul_x !== 5'h1F || bul_y !== 5'h1F)
      begin failures++; $display("FAIL expire_park got fb %b (%0d,%0d) want fb 0 (31,31)", mybul_state_feedback, bul_x, bul_y); end
    clk_4Hz = 1'b1; cyc();
    checks++;
    if (mybul_state_feedback !== 1'b0) begin failures++; $display("FAIL expire_idle got fb %b want 0", mybul_state_feedback); end
  endtask

  task automatic test_hit();
    bit found = 0, saw_hit = 0, saw_x0 = 0, ended = 0;
    do_reset();
    enemy1_x = 5'd12; enemy1_y = 5'd12; enemy2_x = 5'd5; enemy2_y = 5'd2;
    enemy3_x = 5'd0;  enemy3_y = 5'd0;  enemy4_x = 5'd9; enemy4_y = 5'd9;
    enemy_alive = 4'b1111;
    launch(7, 2, 2'b11);
    for (int i = 0; i < 40 && !found; i++) begin
      clk_4Hz = ~clk_4Hz; cyc();
      if (hit_enemy !== 4'b0000) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL hit_timeout got no hit want 0010"); end
    else begin
      checks += 2;
      if (hit_enemy !== 4'b0010) begin failures++; $display("FAIL hit_bits got %b want 0010", hit_enemy); end
      if (bul_x !== 5'd5 || bul_y !== 5'd2) begin failures++; $display("FAIL hit_cell got (%0d,%0d) want (5,2)", bul_x, bul_y); end
      cyc();
      checks++;
      if (hit_enemy !== 4'b0000 || mybul_state_feedback !== 1'b0)
        begin failures++; $display("FAIL hit_after got hit %b fb %b want 0000 0", hit_enemy, mybul_state_feedback); end
    end
    do_reset();
    enemy_alive = 4'b1101;
    launch(7, 2, 2'b11);
    for (int i = 0; i < 60 && !ended; i++) begin
      if (bul_x === 5'd0 && mybul_state_feedback === 1'b1) saw_x0 = 1;
      if (hit_enemy !== 4'b0000) saw_hit = 1;
      clk_4Hz = ~clk_4Hz; cyc();
      if (mybul_state_feedback === 1'b0) ended = 1;
    end
    checks += 3;
    if (!saw_x0) begin failures++; $display("FAIL dead_reach_x0 got no x=0 want x=0 reached"); end
    if (saw_hit) begin failures++; $display("FAIL dead_no_hit got hit want none"); end
    if (!ended) begin failures++; $display("FAIL dead_expire_timeout got fb 1 want 0"); end
  endtask

  task automatic test_hit_tick();
    do_reset();
    enemy1_x = 5'd20; enemy1_y = 5'd20; enemy_alive = 4'b0001;
    launch(8, 8, 2'b10);
    enemy1_x = 5'd8; enemy1_y = 5'd8; clk_4Hz = 1'b1;
    cyc();
    checks += 2;
    if (bul_x !== 5'd8 || bul_y !== 5'd8) begin failures++; $display("FAIL hit_tick_cell got (%0d,%0d) want (8,8)", bul_x, bul_y); end
    if (hit_enemy !== 4'b0001) begin failures++; $display("FAIL hit_tick_bits got %b want 0001", hit_enemy); end
    cyc();
    checks++;
    if (mybul_state_feedback !== 1'b0) begin failures++; $display("FAIL hit_tick_done got fb %b want 0", mybul_state_feedback); end
  endtask

  task automatic test_back_to_back();
    int fb_seen = 0;
    do_reset();
    tank_x = 5'd15; tank_y = 5'd0; tank_dir = 2'b10; bul_sht = 1'b1; bul_en = 1'b1;
    cyc();
    clk_4Hz = 1'b1; cyc();
    clk_4Hz = 1'b0; cyc();
    checks++;
    if (mybul_state_feedback !== 1'b0) begin failures++; $display("FAIL refire_gap got fb %b want 0", mybul_state_feedback); end
    cyc();
    bul_sht = 1'b0;
    checks++;
    if (mybul_state_feedback !== 1'b1 || bul_x !== 5'd15) begin failures++; $display("FAIL refire_once got fb %b x %0d want fb 1 x 15", mybul_state_feedback, bul_x); end
    clk_4Hz = 1'b1; cyc();
    clk_4Hz = 1'b0; cyc();
    bul_sht = 1'b1; bul_en = 1'b0;
    repeat (5) begin
      cyc();
      if (mybul_state_feedback === 1'b1) fb_seen++;
    end
    checks++;
    if (fb_seen != 0) begin failures++; $display("FAIL en_low_launch got %0d fb cycles want 0", fb_seen); end
    bul_sht = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    launch(4, 4, 2'b00);
    clk_4Hz = 1'b1; cyc();
    rst = 1'b1; cyc();
    rst = 1'b0;
    checks++;
    if (bul_x !== 5'h1F || bul_y !== 5'h1F || mybul_state_feedback !== 1'b0 || hit_enemy !== 4'b0000)
      begin failures++; $display("FAIL reset_mid got (%0d,%0d) fb %b hit %b want (31,31) fb 0 hit 0000", bul_x, bul_y, mybul_state_feedback, hit_enemy); end
    do_reset();
    launch(0, 0, 2'b10);
    clk_4Hz = 1'b1; repeat (3) cyc();
    clk_4Hz = 1'b0; repeat (3) cyc();
    checks++;
    if (bul_x !== 5'(STEPS) || bul_y !== 5'd0) begin failures++; $display("FAIL one_period got (%0d,%0d) want (%0d,0)", bul_x, bul_y, STEPS); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      bul_sht  = ($urandom_range(0, 3) == 0);
      bul_en   = ($urandom_range(0, 3) != 0);
      tank_x   = 5'($urandom_range(3, 9));
      tank_y   = 5'($urandom_range(3, 9));
      tank_dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) clk_4Hz = ~clk_4Hz;
      if ($urandom_range(0, 7) == 0) begin
        enemy1_x = 5'($urandom_range(0, 12)); enemy1_y = 5'($urandom_range(0, 12));
        enemy2_x = 5'($urandom_range(0, 12)); enemy2_y = 5'($urandom_range(0, 12));
        enemy3_x = 5'($urandom_range(0, 12)); enemy3_y = 5'($urandom_range(0, 12));
        enemy4_x = 5'($urandom_range(0, 31)); enemy4_y = 5'($urandom_range(0, 31));
        enemy_alive = 4'($urandom_range(0, 15));
      end
      cyc();
      checks += 4;
      if (bul_x !== exp_bx()) begin failures++; $display("FAIL rand_bul_x n=%0d got %0d want %0d", n, bul_x, exp_bx()); end
      if (bul_y !== exp_by()) begin failures++; $display("FAIL rand_bul_y n=%0d got %0d want %0d", n, bul_y, exp_by()); end
      if (mybul_state_feedback !== (m_mode != 0)) begin failures++; $display("FAIL rand_fb n=%0d got %b want %b", n, mybul_state_feedback, m_mode != 0); end
      if (hit_enemy !== m_hit) begin failures++; $display("FAIL rand_hit n=%0d got %b want %b", n, hit_enemy, m_hit); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_4Hz = 1'b0; bul_en = 1'b0; bul_sht = 1'b0;
    tank_x = 5'd0; tank_y = 5'd0; tank_dir = 2'b00;
    enemy1_x = 5'd31; enemy1_y = 5'd31; enemy2_x = 5'd31; enemy2_y = 5'd31;
    enemy3_x = 5'd31; enemy3_y = 5'd31; enemy4_x = 5'd31; enemy4_y = 5'd31;
    enemy_alive = 4'b0000;
    #2;
    test_reset();
    test_launch_fly();
    test_expire();
    test_hit();
    test_hit_tick();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mybullet_app.md
MYBULLET_APP -- requirements
Module: mybullet_app

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous reset, active-high.
REQ-003 clk_4Hz  input  1  movement timebase, sampled as data in the clk domain; never used as a clock.
REQ-004 bul_en  input  1  enable; fire requests are accepted only while it is 1.
REQ-005 bul_sht  input  1  fire request level from the player tank.
REQ-006 tank_x, tank_y  input  5 each  player tank cell, used as the launch cell.
REQ-007 tank_dir  input  2  launch direction: 00 y+1, 01 y-1, 10 x+1, 11 x-1.
REQ-008 enemy1_x..enemy4_x, enemy1_y..enemy4_y  input  5 each  enemy tank cells.
REQ-009 enemy_alive  input  4  bit i-1 set means enemy i is alive and hittable.
REQ-010 bul_x, bul_y  output  5 each  registered bullet cell; 5'h1F/5'h1F (parked) when no bullet is in flight.
REQ-011 mybul_state_feedback  output  1  registered; 1 while a bullet is in flight.
REQ-012 hit_enemy  output  4  registered one-clk pulse; bit i-1 set means enemy i was struck.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, FLY and DONE.
REQ-014 IDLE: if bul_sht=1 and bul_en=1 at edge N, then at edge N+1 the block SHALL enter FLY with bul_x=tank_x, bul_y=tank_y, mybul_state_feedback=1 and tank_dir latched; otherwise it stays in IDLE.
REQ-015 A tick SHALL be defined as clk_4Hz=1 while the registered previous sample of clk_4Hz was 0 (rising edge).
REQ-016 FLY: on a tick, the block SHALL step one cell in the latched direction, using 5-bit arithmetic.
REQ-017 The field SHALL be x 0..15, y 0..19; if the next cell would be x>15, y>19, or below 0 (no wrap permitted), the block SHALL go to DONE without moving.
REQ-018 Hit check in FLY (every clk): bullet cell equals enemy i cell with enemy_alive[i-1]=1 -> hit_enemy[i-1]=1 for one clk and go to DONE; multiple matches set multiple bits.
REQ-019 A hit and a tick in the same cycle: the hit SHALL win and no step occurs.
REQ-020 DONE SHALL last exactly one clk: mybul_state_feedback=0, bul_x/bul_y=5'h1F, hit_enemy=0; the next state is IDLE.
REQ-021 bul_sht SHALL be ignored in FLY and DONE; a new shot requires bul_sht=1 sampled in IDLE, so a held bul_sht refires on the edge after DONE.
REQ-022 bul_en falling to 0 during FLY SHALL NOT abort the flight.
REQ-023 The parked cell 5'h1F is off-field and SHALL never produce a hit.

Reset
REQ-024 rst=1 at any edge, including mid-flight, SHALL force IDLE, bul_x=bul_y=5'h1F, mybul_state_feedback=0, hit_enemy=0, latched direction=00 and the clk_4Hz previous sample=0.
REQ-025 The first accepted shot after reset release SHALL be possible at the first edge with rst=0.

Configuration
REQ-026 With macro MYBUL_FAST_EN defined, a tick SHALL be either edge of clk_4Hz (8 steps/s); without it, rising edges only (4 steps/s).

Verification
REQ-027 Reset, then bul_sht=1, bul_en=1, tank=(5,5), dir=00 -> next clk: feedback=1, bul=(5,5); after 3 rising ticks bul=(5,8).
REQ-028 Launch at (3,19), dir=00 -> first tick: no move, one-clk DONE (feedback=0, bul=(31,31)), then IDLE.
REQ-029 Launch at (7,2), dir=11, enemy2 at (5,2) alive -> after 2 ticks hit_enemy=4'b0010 for 1 clk, then feedback=0; the same with enemy_alive[1]=0 -> flight continues to x=0, then expires on the next tick.
REQ-030 A hit condition coincident with a tick -> bullet position unchanged, hit pulse asserted, DONE.
REQ-031 bul_sht held high across a flight -> exactly one relaunch, on the edge after DONE; bul_en=0 in IDLE -> no launch.
REQ-032 rst pulsed mid-FLY -> IDLE, bul=(31,31), feedback=0 on the next edge; with MYBUL_FAST_EN, dir=10 from (0,0) over one full clk_4Hz period -> bul=(2,0).
